// File: rtl/bitcount_checker.sv
// Receive-side checker for a free-running 4-bit counter stream: verifies +1 mod 16
// per valid sample, tracks lock via HUNT/SYNC/LOCKED, and keeps saturating stats.
module bitcount_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int STAT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic              cnt_vld,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count,
    output logic [1:0]        state
);

    // cnt_vld is a valid-only qualifier with no ready: the checker never stalls the
    // source, and every cycle with cnt_vld=0 is a no-op for all checking state.

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [3:0]        LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0]        UNLOCK_C = 4'(UNLOCK_CNT);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    state_e            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic [3:0]        match_q, match_d;
    logic [3:0]        miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_pulse_q, err_pulse_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
    logic [STAT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [3:0] expected;
    logic       sample_ok;
    logic       err_evt;
    logic       wrap_evt;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    assign expected  = prev_q + 4'd1;
    assign sample_ok = (cnt_in == expected);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;

    // Next-state and event decode; prev realigns to every valid sample in all states.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        match_d  = match_q;
        miss_d   = miss_q;
        err_evt  = 1'b0;
        wrap_evt = 1'b0;
        if (cnt_vld) begin
            prev_d = cnt_in;
            case (state_q)
                ST_HUNT: begin
                    match_d = 4'd0;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (sample_ok) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_C) begin
                            state_d = ST_LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (sample_ok) begin
                        miss_d   = 4'd0;
                        wrap_evt = (prev_q == 4'hF);
                    end else begin
                        err_evt = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == UNLOCK_C) begin
                            state_d = ST_HUNT;
                            match_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Statistics: clear wins over a same-cycle increment; both stick at all-ones.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (clr_stats) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            if (err_evt && (err_cnt_q != STAT_MAX)) begin
                err_cnt_d = err_cnt_q + STAT_ONE;
            end
            if (wrap_evt && (wrap_cnt_q != STAT_MAX)) begin
                wrap_cnt_d = wrap_cnt_q + STAT_ONE;
            end
        end
    end

    always_comb begin
        locked_d    = (state_d == ST_LOCKED);
        err_pulse_d = err_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            prev_q      <= 4'd0;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign state      = state_q;
    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_cnt_q;
    assign wrap_count = wrap_cnt_q;

endmodule

// File: tb/tb_bitcount_checker.sv
// Bench for bitcount_checker: a default-parameter instance and a LOCK_CNT=1/UNLOCK_CNT=15
// instance share stimulus; a behavioural model feeds per-instance expected queues.
module tb_bitcount_checker;

    localparam int W = 20;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       cnt_vld;
    logic       clr_stats;

    logic       locked, err_pulse;
    logic [7:0] err_count, wrap_count;
    logic [1:0] state;
    logic       s_locked, s_err_pulse;
    logic [7:0] s_err_count, s_wrap_count;
    logic [1:0] s_state;

    int tests_run = 0;
    int fails     = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_s_q[$];

    typedef struct packed {
        logic [1:0] st;
        logic       lk;
        logic       ep;
        logic [7:0] ec;
        logic [7:0] wc;
        logic [3:0] prev;
        logic [3:0] mc;
        logic [3:0] ms;
    } model_t;

    model_t m_d = '0;
    model_t m_s = '0;

    bitcount_checker #(.LOCK_CNT(4), .UNLOCK_CNT(2), .STAT_W(8)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr_stats(clr_stats),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .wrap_count(wrap_count), .state(state)
    );

    bitcount_checker #(.LOCK_CNT(1), .UNLOCK_CNT(15), .STAT_W(8)) dut_sat (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr_stats(clr_stats),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .wrap_count(s_wrap_count), .state(s_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic model_t model_step(model_t m, logic r, logic v, logic [3:0] c,
                                          logic clr, logic [3:0] lk_n, logic [3:0] ul_n);
        model_t     n;
        logic       e;
        logic       w;
        logic [3:0] exp4;
        n = '0;
        if (r) return n;
        n    = m;
        n.ep = 1'b0;
        e    = 1'b0;
        w    = 1'b0;
        exp4 = m.prev + 4'd1;
        if (v) begin
            case (m.st)
                2'd0: begin n.mc = 4'd0; n.st = 2'd1; end
                2'd1: begin
                    if (c == exp4) begin
                        n.mc = m.mc + 4'd1;
                        if (n.mc == lk_n) begin n.st = 2'd2; n.ms = 4'd0; end
                    end else begin
                        n.mc = 4'd0;
                    end
                end
                2'd2: begin
                    if (c == exp4) begin
                        n.ms = 4'd0;
                        if (m.prev == 4'hF) w = 1'b1;
                    end else begin
                        e    = 1'b1;
                        n.ep = 1'b1;
                        n.ms = m.ms + 4'd1;
                        if (n.ms == ul_n) begin n.st = 2'd0; n.mc = 4'd0; end
                    end
                end
                default: n.st = 2'd0;
            endcase
            n.prev = c;
        end
        if (clr) begin
            n.ec = 8'd0;
            n.wc = 8'd0;
        end else begin
            if (e && m.ec != 8'hFF) n.ec = m.ec + 8'd1;
            if (w && m.wc != 8'hFF) n.wc = m.wc + 8'd1;
        end
        n.lk = (n.st == 2'd2);
        return n;
    endfunction

    function automatic logic [W-1:0] pack(model_t m);
        return {m.st, m.lk, m.ep, m.ec, m.wc};
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic v, input logic [3:0] c, input logic clr, input logic r);
        rst       = r;
        cnt_vld   = v;
        cnt_in    = c;
        clr_stats = clr;
        m_d = model_step(m_d, r, v, c, clr, 4'd4, 4'd2);
        m_s = model_step(m_s, r, v, c, clr, 4'd1, 4'd15);
        exp_q.push_back(pack(m_d));
        exp_s_q.push_back(pack(m_s));
        @(posedge clk);
        #2;
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] o;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {state, locked, err_pulse, err_count, wrap_count};
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL sb_default t=%0t got st/lk/ep/ec/wc=%0d/%0b/%0b/%0d/%0d expected %0d/%0b/%0b/%0d/%0d",
                         $time, o[19:18], o[17], o[16], o[15:8], o[7:0],
                         e[19:18], e[17], e[16], e[15:8], e[7:0]);
            end
        end
        if (exp_s_q.size() > 0) begin
            e = exp_s_q.pop_front();
            o = {s_state, s_locked, s_err_pulse, s_err_count, s_wrap_count};
            tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL sb_sat t=%0t got st/lk/ep/ec/wc=%0d/%0b/%0b/%0d/%0d expected %0d/%0b/%0b/%0d/%0d",
                         $time, o[19:18], o[17], o[16], o[15:8], o[7:0],
                         e[19:18], e[17], e[16], e[15:8], e[7:0]);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle(1'b1, 4'hA, 1'b1, 1'b1);
        tests_run++;
        if ({state, locked, err_pulse, err_count, wrap_count} !== '0) begin
            fails++;
            $display("FAIL reset_values got st=%0d lk=%0b ep=%0b ec=%0d wc=%0d expected all 0",
                     state, locked, err_pulse, err_count, wrap_count);
        end
    endtask

    task automatic test_lock();
        cycle(1'b1, 4'd0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd1) begin fails++; $display("FAIL lock_sync got state=%0d expected 1", state); end
        for (int v = 1; v <= 3; v++) cycle(1'b1, 4'(v), 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b0) begin fails++; $display("FAIL lock_early got locked=%0b expected 0", locked); end
        cycle(1'b1, 4'd4, 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b1 || state !== 2'd2) begin
            fails++; $display("FAIL lock_rise got locked=%0b state=%0d expected 1/2", locked, state);
        end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        for (int v = 5; v <= 15; v++) begin cycle(1'b1, 4'(v), 1'b0, 1'b0); pulses += int'(err_pulse); end
        for (int r = 0; r < 2; r++)
            for (int v = 0; v <= 15; v++) begin cycle(1'b1, 4'(v), 1'b0, 1'b0); pulses += int'(err_pulse); end
        cycle(1'b1, 4'd0, 1'b0, 1'b0);
        pulses += int'(err_pulse);
        tests_run++;
        if (wrap_count !== 8'd3 || err_count !== 8'd0 || pulses != 0) begin
            fails++;
            $display("FAIL wrap_three got wc=%0d ec=%0d pulses=%0d expected 3/0/0", wrap_count, err_count, pulses);
        end
    endtask

    task automatic test_single_error();
        test_reset();
        for (int v = 0; v <= 5; v++) cycle(1'b1, 4'(v), 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b0, 1'b0);
        tests_run++;
        if (err_pulse !== 1'b1) begin fails++; $display("FAIL single_pulse got %0b expected 1", err_pulse); end
        cycle(1'b1, 4'd10, 1'b0, 1'b0);
        tests_run++;
        if (err_pulse !== 1'b0) begin fails++; $display("FAIL single_realign got ep=%0b expected 0", err_pulse); end
        cycle(1'b1, 4'd11, 1'b0, 1'b0);
        tests_run++;
        if (err_count !== 8'd1 || locked !== 1'b1) begin
            fails++; $display("FAIL single_stay got ec=%0d lk=%0b expected 1/1", err_count, locked);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        test_reset();
        for (int v = 0; v <= 5; v++) cycle(1'b1, 4'(v), 1'b0, 1'b0);
        cycle(1'b1, 4'd9, 1'b0, 1'b0);
        pulses += int'(err_pulse);
        cycle(1'b1, 4'd2, 1'b0, 1'b0);
        pulses += int'(err_pulse);
        tests_run++;
        if (pulses != 2 || err_count !== 8'd2 || state !== 2'd0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL unlock got pulses=%0d ec=%0d st=%0d lk=%0b expected 2/2/0/0", pulses, err_count, state, locked);
        end
        for (int v = 3; v <= 6; v++) cycle(1'b1, 4'(v), 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b0) begin fails++; $display("FAIL relock_early got %0b expected 0", locked); end
        cycle(1'b1, 4'd7, 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b1) begin fails++; $display("FAIL relock got %0b expected 1", locked); end
    endtask

    task automatic test_saturate();
        logic [3:0] p;
        test_reset();
        cycle(1'b1, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 4'd1, 1'b0, 1'b0);
        p = 4'd1;
        for (int r = 0; r < 19; r++) begin
            for (int k = 0; k < 14; k++) begin p = p + 4'd2; cycle(1'b1, p, 1'b0, 1'b0); end
            p = p + 4'd1;
            cycle(1'b1, p, 1'b0, 1'b0);
        end
        tests_run++;
        if (s_err_count !== 8'hFF || s_locked !== 1'b1) begin
            fails++; $display("FAIL sat_hold got ec=%0d lk=%0b expected 255/1", s_err_count, s_locked);
        end
        p = p + 4'd2;
        cycle(1'b1, p, 1'b1, 1'b0);
        tests_run++;
        if (s_err_count !== 8'd0 || s_err_pulse !== 1'b1) begin
            fails++; $display("FAIL clr_priority got ec=%0d ep=%0b expected 0/1", s_err_count, s_err_pulse);
        end
        p = p + 4'd2;
        cycle(1'b1, p, 1'b0, 1'b0);
        tests_run++;
        if (s_err_count !== 8'd1) begin fails++; $display("FAIL after_clr got ec=%0d expected 1", s_err_count); end
    endtask

    task automatic test_gaps_and_rst();
        test_reset();
        cycle(1'b1, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        cycle(1'b1, 4'd1, 1'b0, 1'b0);
        cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd1 || err_pulse !== 1'b0) begin
            fails++; $display("FAIL gaps got st=%0d ep=%0b expected 1/0", state, err_pulse);
        end
        cycle(1'b1, 4'd3, 1'b0, 1'b1);
        tests_run++;
        if ({state, locked, err_pulse, err_count, wrap_count} !== '0) begin
            fails++; $display("FAIL mid_rst got st=%0d lk=%0b ep=%0b ec=%0d wc=%0d expected all 0",
                              state, locked, err_pulse, err_count, wrap_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] rp = 4'd0;
        logic       v;
        logic [3:0] c;
        test_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : rp + 4'd1;
            if (v) rp = c;
            cycle(v, c, ($urandom_range(0, 40) == 0), ($urandom_range(0, 199) == 0));
        end
    endtask

    initial begin
        rst = 1'b1; cnt_vld = 1'b0; cnt_in = 4'd0; clr_stats = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_single_error();
        test_back_to_back();
        test_saturate();
        test_gaps_and_rst();
        test_random();
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
